// File: rtl/pwm_compare_deadtime_pkg.sv
// Shared widths and enumerations for the compare / dead-time PWM leg.
package pwm_compare_deadtime_pkg;

    localparam int PWMCOUNT_WIDTH = 16;
    localparam int DEADTIME_WIDTH = 10;

    typedef enum logic [1:0] {
        LOAD_ZERO,
        LOAD_PERIOD,
        LOAD_BOTH,
        LOAD_IMMEDIATE
    } load_mode_t;

    typedef enum logic {
        PWM_OFF,
        PWM_ON
    } pwm_onoff_t;

    typedef enum logic [2:0] {
        OFF,
        H_ON,
        L_ON,
        DT_TO_H,
        DT_TO_L
    } dt_state_t;

endpackage

// File: rtl/pwm_compare_deadtime_leg.sv
// Dead-time FSM: turns the registered reference level into a
// non-overlapping high/low gate pair.
module deadtime_leg
    import pwm_compare_deadtime_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      ref_q,
    input  logic [DEADTIME_WIDTH-1:0] dead_time,
    output logic                      pwm_h,
    output logic                      pwm_l
);

    dt_state_t                 state;
    logic [DEADTIME_WIDTH-1:0] cnt;
    logic                      cold;
    logic                      dt_zero;
    logic                      cnt_done;
    logic [DEADTIME_WIDTH-1:0] cnt_next;

    assign dt_zero  = (dead_time == '0);
    assign cnt_done = (cnt[DEADTIME_WIDTH-1:1] == '0);
    assign cnt_next = cnt_done ? '0 : cnt - DEADTIME_WIDTH'(1);

    // cold marks an interval started from OFF: neither gate was on, so a
    // reference flip only retargets the interval instead of skipping it.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            state <= OFF;
            cnt   <= '0;
            cold  <= 1'b0;
            pwm_h <= 1'b0;
            pwm_l <= 1'b0;
        end else begin
            unique case (state)
                OFF: begin
                    if (dt_zero) begin
                        state <= ref_q ? H_ON : L_ON;
                        pwm_h <= ref_q;
                        pwm_l <= !ref_q;
                    end else begin
                        state <= ref_q ? DT_TO_H : DT_TO_L;
                        cnt   <= dead_time;
                        cold  <= 1'b1;
                    end
                end
                H_ON: begin
                    if (!ref_q) begin
                        pwm_h <= 1'b0;
                        if (dt_zero) begin
                            state <= L_ON;
                            pwm_l <= 1'b1;
                        end else begin
                            state <= DT_TO_L;
                            cnt   <= dead_time;
                        end
                    end
                end
                L_ON: begin
                    if (ref_q) begin
                        pwm_l <= 1'b0;
                        if (dt_zero) begin
                            state <= H_ON;
                            pwm_h <= 1'b1;
                        end else begin
                            state <= DT_TO_H;
                            cnt   <= dead_time;
                        end
                    end
                end
                DT_TO_H: begin
                    if (!ref_q && cold) begin
                        state <= DT_TO_L;
                        cnt   <= cnt_next;
                    end else if (!ref_q) begin
                        state <= L_ON;
                        pwm_l <= 1'b1;
                        cnt   <= '0;
                    end else if (cnt_done) begin
                        state <= H_ON;
                        pwm_h <= 1'b1;
                        cnt   <= '0;
                        cold  <= 1'b0;
                    end else begin
                        cnt   <= cnt_next;
                    end
                end
                DT_TO_L: begin
                    if (ref_q && cold) begin
                        state <= DT_TO_H;
                        cnt   <= cnt_next;
                    end else if (ref_q) begin
                        state <= H_ON;
                        pwm_h <= 1'b1;
                        cnt   <= '0;
                    end else if (cnt_done) begin
                        state <= L_ON;
                        pwm_l <= 1'b1;
                        cnt   <= '0;
                        cold  <= 1'b0;
                    end else begin
                        cnt   <= cnt_next;
                    end
                end
                default: begin
                    state <= OFF;
                    cnt   <= '0;
                    pwm_h <= 1'b0;
                    pwm_l <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pwm_compare_deadtime.sv
// One half-bridge leg: shadowed compare, carrier comparator and
// dead-time gate generation.
module pwm_compare_deadtime
    import pwm_compare_deadtime_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic [PWMCOUNT_WIDTH-1:0] carrier,
    input  logic [PWMCOUNT_WIDTH-1:0] period,
    input  logic [PWMCOUNT_WIDTH-1:0] compare,
    input  logic [DEADTIME_WIDTH-1:0] dead_time,
    input  load_mode_t                load_mode,
    input  pwm_onoff_t                pwm_onoff,
    output logic                      pwm_h,
    output logic                      pwm_l,
    output logic                      load_event
);

    logic [PWMCOUNT_WIDTH-1:0] cmp_sh;
    logic                      ref_q;
    logic                      at_zero;
    logic                      at_period;
    logic                      enable;
    logic                      load_hit;

    assign at_zero   = (carrier == '0);
    assign at_period = (carrier == period);
    assign enable    = (pwm_onoff == PWM_ON);

    always_comb begin
        load_hit = 1'b0;
        unique case (load_mode)
            LOAD_ZERO:      load_hit = at_zero;
            LOAD_PERIOD:    load_hit = at_period;
            LOAD_BOTH:      load_hit = at_zero || at_period;
            LOAD_IMMEDIATE: load_hit = 1'b1;
        endcase
        if (!enable)
            load_hit = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmp_sh     <= '0;
            ref_q      <= 1'b0;
            load_event <= 1'b0;
        end else begin
            if (load_hit)
                cmp_sh <= compare;
            load_event <= load_hit;
            ref_q      <= (carrier < cmp_sh);
        end
    end

    deadtime_leg u_leg (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .ref_q     (ref_q),
        .dead_time (dead_time),
        .pwm_h     (pwm_h),
        .pwm_l     (pwm_l)
    );

endmodule
